// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// instruction fields, ALU operations and datapath mux codes.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_DECODE, S_EXEC, S_RWB, S_MEMADR, S_MEMRD, S_MEMWB,
      S_MEMWR, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_JUMPR, S_FAULT
   } state_t;

   // opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // ALU operations
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B-operand select
   localparam logic [1:0] SRCB_RT    = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   // next-PC select
   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funccode -> ALU operation, with a flag for codes the ALU cannot execute.
module mips_alu_decoder
   import mips_mc_pkg::*;
(
   input  logic [5:0] funccode,
   output logic [2:0] aluopr,
   output logic       illegal
);

   // jr is not an ALU op; when supported it is peeled off in DECODE before EXEC
   always_comb begin
      aluopr  = ALU_ADD;
      illegal = 1'b0;
      case (funccode)
         FN_ADD:  aluopr = ALU_ADD;
         FN_SUB:  aluopr = ALU_SUB;
         FN_AND:  aluopr = ALU_AND;
         FN_OR:   aluopr = ALU_OR;
         FN_SLT:  aluopr = ALU_SLT;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port with a ready handshake and a wait-cycle timeout.
// Optional jal/jr support is enabled by defining MIPS_MC_JAL_JR_EN.
module mips_multicycle_controller
   import mips_mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 5
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funccode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] aluopr,
   output logic [1:0] pcsrc,
   output logic       pctoreg,
   output logic       instr_done,
   output logic       fault
);

   state_t           state, state_nx;
   logic [TMO_W-1:0] wait_cnt;
   logic [2:0]       dec_aluopr;
   logic             dec_illegal;
   logic             mem_req, timed_out;

   mips_alu_decoder u_alu_dec (
      .funccode (funccode),
      .aluopr   (dec_aluopr),
      .illegal  (dec_illegal)
   );

   // the MEM_TIMEOUT-th miss faults; a ready on that same cycle completes instead
   assign mem_req   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign timed_out = mem_req && !mem_ready && (wait_cnt == TMO_W'(MEM_TIMEOUT - 1));

   // next-state selection
   always_comb begin
      state_nx = state;
      case (state)
         S_RESET:  state_nx = S_FETCH;
         S_FETCH:  if (mem_ready) state_nx = S_DECODE;
                   else if (timed_out) state_nx = S_FAULT;
         S_DECODE: begin
            case (opcode)
`ifdef MIPS_MC_JAL_JR_EN
               OP_RTYPE: state_nx = (funccode == FN_JR) ? S_JUMPR : S_EXEC;
               OP_JAL:   state_nx = S_JUMP;
`else
               OP_RTYPE: state_nx = S_EXEC;
`endif
               OP_LW, OP_SW: state_nx = S_MEMADR;
               OP_BEQ:   state_nx = S_BRANCH;
               OP_ADDI:  state_nx = S_ADDIEX;
               OP_J:     state_nx = S_JUMP;
               default:  state_nx = S_FAULT;
            endcase
         end
         S_EXEC:   state_nx = dec_illegal ? S_FAULT : S_RWB;
         S_MEMADR: state_nx = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
                   else if (timed_out) state_nx = S_FAULT;
         S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
                   else if (timed_out) state_nx = S_FAULT;
         S_RWB, S_MEMWB, S_BRANCH, S_ADDIWB, S_JUMP, S_JUMPR:
                   state_nx = S_FETCH;
         S_ADDIEX: state_nx = S_ADDIWB;
         S_FAULT:  state_nx = S_FAULT;
         default:  state_nx = S_FAULT;
      endcase
   end

   // state register and wait counter; counter restarts whenever a request state is entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RESET;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= (mem_req && !mem_ready && state_nx == state) ? wait_cnt + TMO_W'(1) : '0;
      end
   end

   // Moore decode of datapath controls; only FETCH/MEMWR ready, BRANCH zero and EXEC funccode feed through
   always_comb begin
      pcwrite    = 1'b0;
      iord       = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_RT;
      aluopr     = ALU_AND;
      pcsrc      = PC_ALU;
      pctoreg    = 1'b0;
      instr_done = 1'b0;
      fault      = 1'b0;
      case (state)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = SRCB_FOUR;
            aluopr  = ALU_ADD;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         S_DECODE: begin
            alusrcb = SRCB_IMMSH;
            aluopr  = ALU_ADD;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluopr  = dec_aluopr;
         end
         S_RWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluopr  = ALU_ADD;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            memwrite   = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            aluopr     = ALU_SUB;
            pcsrc      = PC_ALUOUT;
            pcwrite    = zero;
            instr_done = 1'b1;
         end
         S_ADDIWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            pcsrc      = PC_JUMP;
            pcwrite    = 1'b1;
            instr_done = 1'b1;
`ifdef MIPS_MC_JAL_JR_EN
            pctoreg    = (opcode == OP_JAL);
`endif
         end
`ifdef MIPS_MC_JAL_JR_EN
         S_JUMPR: begin
            pcsrc      = PC_RS;
            pcwrite    = 1'b1;
            instr_done = 1'b1;
         end
`endif
         S_FAULT:  fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed table-driven bench for mips_multicycle_controller (MEM_TIMEOUT=4),
// plus hand sequences for fault, timeout, jal/jr and async reset.
module tb_mips_multicycle_controller;

   typedef struct packed {
      logic pcwrite, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluopr;
      logic [1:0] pcsrc;
      logic pctoreg, instr_done, fault;
   } ctl_t;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       rdy;
      ctl_t       exp;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funccode;
   logic       zero, mem_ready;
   logic       pcwrite, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluopr;
   logic       pctoreg, instr_done, fault;
   ctl_t       act;

   int checks = 0;
   int errors = 0;
   vec_t vq[$];

   localparam ctl_t ZERO = '0;

   always #5 clk = ~clk;

   mips_multicycle_controller #(.MEM_TIMEOUT(4), .TMO_W(5)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funccode(funccode), .zero(zero),
      .mem_ready(mem_ready), .pcwrite(pcwrite), .iord(iord), .memread(memread),
      .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluopr(aluopr),
      .pcsrc(pcsrc), .pctoreg(pctoreg), .instr_done(instr_done), .fault(fault)
   );

   assign act = {pcwrite, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                 alusrca, alusrcb, aluopr, pcsrc, pctoreg, instr_done, fault};

   // expected control words per state
   function automatic ctl_t f_fetch(logic r);
      ctl_t c = '0; c.memread = 1; c.alusrcb = 2'd1; c.aluopr = 3'b010;
      c.irwrite = r; c.pcwrite = r; return c;
   endfunction
   function automatic ctl_t f_decode();
      ctl_t c = '0; c.alusrcb = 2'd3; c.aluopr = 3'b010; return c;
   endfunction
   function automatic ctl_t f_exec(logic [2:0] op);
      ctl_t c = '0; c.alusrca = 1; c.alusrcb = 2'd0; c.aluopr = op; return c;
   endfunction
   function automatic ctl_t f_rwb();
      ctl_t c = '0; c.regdst = 1; c.regwrite = 1; c.instr_done = 1; return c;
   endfunction
   function automatic ctl_t f_immadd();
      ctl_t c = '0; c.alusrca = 1; c.alusrcb = 2'd2; c.aluopr = 3'b010; return c;
   endfunction
   function automatic ctl_t f_memrd();
      ctl_t c = '0; c.memread = 1; c.iord = 1; return c;
   endfunction
   function automatic ctl_t f_memwb();
      ctl_t c = '0; c.memtoreg = 1; c.regwrite = 1; c.instr_done = 1; return c;
   endfunction
   function automatic ctl_t f_memwr(logic r);
      ctl_t c = '0; c.memwrite = 1; c.iord = 1; c.instr_done = r; return c;
   endfunction
   function automatic ctl_t f_branch(logic z);
      ctl_t c = '0; c.alusrca = 1; c.aluopr = 3'b110; c.pcsrc = 2'd1;
      c.pcwrite = z; c.instr_done = 1; return c;
   endfunction
   function automatic ctl_t f_addiwb();
      ctl_t c = '0; c.regwrite = 1; c.instr_done = 1; return c;
   endfunction
   function automatic ctl_t f_jump(logic jal);
      ctl_t c = '0; c.pcsrc = 2'd2; c.pcwrite = 1; c.pctoreg = jal; c.instr_done = 1; return c;
   endfunction
   function automatic ctl_t f_jumpr();
      ctl_t c = '0; c.pcsrc = 2'd3; c.pcwrite = 1; c.instr_done = 1; return c;
   endfunction
   function automatic ctl_t f_fault();
      ctl_t c = '0; c.fault = 1; return c;
   endfunction

   task automatic check(input string name, input ctl_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic add(input string name, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input ctl_t exp);
      vec_t v;
      v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   // one clock cycle: drive after the edge, compare mid-cycle, advance
   task automatic apply(input vec_t v);
      rst = v.rst; opcode = v.op; funccode = v.fn; zero = v.z; mem_ready = v.rdy;
      #2;
      check(v.name, v.exp);
      @(posedge clk); #1;
   endtask

   task automatic drive(input string name, input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input ctl_t exp);
      vec_t v;
      v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp; v.name = name;
      apply(v);
   endtask

   task automatic do_reset();
      drive("rst_low", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, ZERO);
      drive("rst_release", 1'b1, 6'd0, 6'd0, 1'b0, 1'b1, ZERO);
   endtask

   initial begin
      logic [5:0] fns[5];
      logic [2:0] ops[5];
      string      nms[5];
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      ops = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      nms = '{"add", "sub", "and", "or", "slt"};

      rst = 1'b0; opcode = '0; funccode = '0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", ZERO);

      // ---- vector table ----
      add("reset_cycle", 1, 6'd0, 6'd0, 0, 1, ZERO);
      for (int i = 0; i < 5; i++) begin
         add({nms[i], "_fetch"},  1, 6'd0, fns[i], 0, 1, f_fetch(1'b1));
         add({nms[i], "_decode"}, 1, 6'd0, fns[i], 0, 0, f_decode());
         add({nms[i], "_exec"},   1, 6'd0, fns[i], 0, 1, f_exec(ops[i]));
         add({nms[i], "_rwb"},    1, 6'd0, fns[i], 0, 0, f_rwb());
      end
      // lw with three wait cycles in MEMRD: writeback lands in cycle 8
      add("lw_fetch",  1, 6'b100011, 6'd0, 0, 1, f_fetch(1'b1));
      add("lw_decode", 1, 6'b100011, 6'd0, 0, 1, f_decode());
      add("lw_memadr", 1, 6'b100011, 6'd0, 0, 1, f_immadd());
      for (int i = 0; i < 3; i++) add("lw_memrd_wait", 1, 6'b100011, 6'd0, 0, 0, f_memrd());
      add("lw_memrd_rdy", 1, 6'b100011, 6'd0, 0, 1, f_memrd());
      add("lw_memwb",     1, 6'b100011, 6'd0, 0, 0, f_memwb());
      // sw with one wait
      add("sw_fetch",     1, 6'b101011, 6'd0, 0, 1, f_fetch(1'b1));
      add("sw_decode",    1, 6'b101011, 6'd0, 0, 0, f_decode());
      add("sw_memadr",    1, 6'b101011, 6'd0, 0, 0, f_immadd());
      add("sw_memwr_wait", 1, 6'b101011, 6'd0, 0, 0, f_memwr(1'b0));
      add("sw_memwr_rdy", 1, 6'b101011, 6'd0, 0, 1, f_memwr(1'b1));
      // fetch stalled MEM_TIMEOUT-1 cycles then ready on the last allowed one
      for (int i = 0; i < 3; i++) add("fetch_wait", 1, 6'b000100, 6'd0, 1, 0, f_fetch(1'b0));
      add("fetch_rdy_boundary", 1, 6'b000100, 6'd0, 1, 1, f_fetch(1'b1));
      add("beq1_decode", 1, 6'b000100, 6'd0, 1, 0, f_decode());
      add("beq1_branch", 1, 6'b000100, 6'd0, 1, 0, f_branch(1'b1));
      add("beq0_fetch",  1, 6'b000100, 6'd0, 0, 1, f_fetch(1'b1));
      add("beq0_decode", 1, 6'b000100, 6'd0, 0, 0, f_decode());
      add("beq0_branch", 1, 6'b000100, 6'd0, 0, 1, f_branch(1'b0));
      add("addi_fetch",  1, 6'b001000, 6'd0, 0, 1, f_fetch(1'b1));
      add("addi_decode", 1, 6'b001000, 6'd0, 0, 0, f_decode());
      add("addi_ex",     1, 6'b001000, 6'd0, 0, 0, f_immadd());
      add("addi_wb",     1, 6'b001000, 6'd0, 0, 0, f_addiwb());
      add("j_fetch",     1, 6'b000010, 6'd0, 0, 1, f_fetch(1'b1));
      add("j_decode",    1, 6'b000010, 6'd0, 0, 0, f_decode());
      add("j_jump",      1, 6'b000010, 6'd0, 0, 0, f_jump(1'b0));
      add("after_j_fetch", 1, 6'b000010, 6'd0, 0, 0, f_fetch(1'b0));
      for (int i = 0; i < vq.size(); i++) apply(vq[i]);

      // ---- illegal funccode 000111 ----
      do_reset();
      drive("bad_fn_fetch",  1, 6'd0, 6'b000111, 0, 1, f_fetch(1'b1));
      drive("bad_fn_decode", 1, 6'd0, 6'b000111, 0, 0, f_decode());
      #2 check_bit("bad_fn_exec_nofault", fault, 1'b0);
      @(posedge clk); #1;
      drive("bad_fn_fault", 1, 6'd0, 6'b000111, 0, 1, f_fault());
      drive("bad_fn_sticky", 1, 6'd0, 6'b100000, 0, 1, f_fault());

      // ---- fetch timeout: four misses ----
      do_reset();
      for (int i = 0; i < 4; i++) drive("tmo_fetch_wait", 1, 6'd0, 6'd0, 0, 0, f_fetch(1'b0));
      drive("tmo_fault", 1, 6'd0, 6'd0, 0, 1, f_fault());
      drive("tmo_fault_sticky", 1, 6'd0, 6'd0, 0, 0, f_fault());
      drive("tmo_rst_clear", 0, 6'd0, 6'd0, 0, 0, ZERO);
      drive("tmo_rst_release", 1, 6'd0, 6'd0, 0, 1, ZERO);

      // ---- jal ----
      drive("jal_fetch",  1, 6'b000011, 6'd0, 0, 1, f_fetch(1'b1));
      drive("jal_decode", 1, 6'b000011, 6'd0, 0, 0, f_decode());
`ifdef MIPS_MC_JAL_JR_EN
      drive("jal_jump",   1, 6'b000011, 6'd0, 0, 0, f_jump(1'b1));
`else
      drive("jal_fault",  1, 6'b000011, 6'd0, 0, 0, f_fault());
`endif

      // ---- jr ----
      do_reset();
      drive("jr_fetch",  1, 6'd0, 6'b001000, 0, 1, f_fetch(1'b1));
      drive("jr_decode", 1, 6'd0, 6'b001000, 0, 0, f_decode());
`ifdef MIPS_MC_JAL_JR_EN
      drive("jr_jumpr",  1, 6'd0, 6'b001000, 0, 0, f_jumpr());
`else
      #2 check_bit("jr_exec_nofault", fault, 1'b0);
      @(posedge clk); #1;
      drive("jr_fault",  1, 6'd0, 6'b001000, 0, 0, f_fault());
`endif

      // ---- async reset while a store is outstanding ----
      do_reset();
      drive("ar_fetch",  1, 6'b101011, 6'd0, 0, 1, f_fetch(1'b1));
      drive("ar_decode", 1, 6'b101011, 6'd0, 0, 0, f_decode());
      drive("ar_memadr", 1, 6'b101011, 6'd0, 0, 0, f_immadd());
      drive("ar_memwr",  1, 6'b101011, 6'd0, 0, 0, f_memwr(1'b0));
      mem_ready = 1'b0;
      #1 check_bit("ar_memwrite_held", memwrite, 1'b1);
      rst = 1'b0;
      #1 check("ar_async_clear", ZERO);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      drive("ar_post_reset_fetch", 1, 6'd0, 6'd0, 0, 1, f_fetch(1'b1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
